// File: rtl/dmem_access_ctrl.sv
// Byte-serial data memory sequencer: splits byte/word loads and stores into
// little-endian byte accesses and stalls the pipeline until the response.
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic [32:0] end_addr;
  logic        last;
  logic [31:0] wsh;

  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  i,
    input logic [7:0]  b
  );
    logic [31:0] m;
    m = 32'h0000_00ff << {i, 3'b000};
    return (w & ~m) | ({24'b0, b} << {i, 3'b000});
  endfunction

  assign end_addr = {1'b0, req_addr} + (req_word ? 33'd4 : 33'd1);
  assign last     = word_q ? (idx_q == 2'd3) : 1'b1;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wsh          = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          word_d  = req_word;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          rdata_d = '0;
          if (end_addr > 33'(MEM_BYTES)) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_addr_d  = req_addr;
            mem_we_d    = req_write;
            mem_re_d    = !req_write;
            mem_wdata_d = req_wdata[7:0];
          end
        end
      end
      ISSUE: begin
        // read data lags its strobe by one cycle
        if (!write_q && idx_q != 2'd0)
          rdata_d = put_byte(rdata_q, idx_q - 2'd1, mem_rdata);
        if (last) begin
          if (write_q) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          idx_d       = idx_q + 2'd1;
          wsh         = wdata_q >> {idx_d, 3'b000};
          mem_addr_d  = addr_q + {30'b0, idx_d};
          mem_we_d    = write_q;
          mem_re_d    = !write_q;
          mem_wdata_d = wsh[7:0];
        end
      end
      DRAIN: begin
        rdata_d      = put_byte(rdata_q, idx_q, mem_rdata);
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = rdata_d;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      word_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign stall      = req_valid && !reset && (state_q != DONE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 22-byte
// memory model and hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_word;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0] mem [0:21];
  bit         fill = 1'b1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int viol   = 0;

  int          rc, nwe, nre, nst, fs, ls;
  logic [31:0] rd;
  logic        er, st_done;
  logic [63:0] wlog;
  int          p0;

  dmem_access_ctrl #(.MEM_BYTES(22)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_word   (req_word),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 22; i++) mem[i] <= 8'(8'h10 + i);
    end else begin
      if (mem_we && mem_addr < 32'd22) mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_re && mem_addr < 32'd22) mem_rdata <= mem[mem_addr[4:0]];
    end
  end

  always @(negedge clk) begin
    if (resp_valid) pulses++;
    if (mem_re && mem_we) viol++;
    if ((mem_re || mem_we) && mem_addr >= 32'd22) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is c0. Returns just after
  // the edge that ends the response cycle, with req_valid still high.
  task automatic do_req(input bit w, input bit wd, input logic [31:0] a,
                        input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_word  = wd;
    req_addr  = a;
    req_wdata = d;
    rc = -1; nwe = 0; nre = 0; nst = 0; fs = -1; ls = -1;
    rd = '0; er = 1'b0; st_done = 1'b1; wlog = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) nst++;
      if (mem_we || mem_re) begin
        if (fs < 0) fs = c;
        ls = c;
      end
      if (mem_we) begin
        nwe++;
        wlog = {wlog[47:0], mem_addr[7:0], mem_wdata};
      end
      if (mem_re) nre++;
      if (resp_valid) begin
        rc = c;
        rd = resp_rdata;
        er = resp_err;
        st_done = stall;
      end
      @(posedge clk);
      #1;
      if (rc >= 0) break;
    end
    if (rc < 0) chk("timeout", 64'(rc), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("rst_ctl", {59'b0, resp_valid, resp_err, mem_re, mem_we, stall}, 0);
    chk("rst_addr", {32'b0, mem_addr}, 0);
    chk("rst_data", {24'b0, mem_wdata, resp_rdata}, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    fill  = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // word store and load back
    p0 = pulses;
    do_req(1'b1, 1'b1, 32'd4, 32'hDEADBEEF);
    req_valid = 1'b0;
    chk("ws_lat", 64'(rc), 64'd5);
    chk("ws_err", {63'b0, er}, 0);
    chk("ws_log", wlog, 64'h04EF_05BE_06AD_07DE);
    chk("ws_win", {32'(fs), 32'(ls)}, {32'd1, 32'd4});
    chk("ws_stall", 64'(nst), 64'd5);
    chk("ws_nre", 64'(nre), 64'd0);
    chk("ws_mem", {32'b0, mem[7], mem[6], mem[5], mem[4]}, 64'hDEADBEEF);
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b1, 32'd4, 32'h0);
    req_valid = 1'b0;
    chk("wl_lat", 64'(rc), 64'd6);
    chk("wl_data", {32'b0, rd}, 64'hDEADBEEF);
    chk("wl_win", {32'(fs), 32'(ls)}, {32'd1, 32'd4});
    chk("wl_cnt", {32'(nre), 32'(nwe)}, {32'd4, 32'd0});
    chk("wl_stall", {31'b0, st_done, 32'(nst)}, {32'd0, 32'd6});
    repeat (3) @(posedge clk);
    #1;
    chk("wl_hold", {32'b0, resp_rdata}, 64'hDEADBEEF);
    chk("pulse12", 64'(pulses - p0), 64'd2);

    // byte store then byte load
    do_req(1'b1, 1'b0, 32'd8, 32'h123456A5);
    req_valid = 1'b0;
    chk("bs_lat", 64'(rc), 64'd2);
    chk("bs_log", {32'(nwe), wlog[31:0]}, {32'd1, 32'h0000_08A5});
    chk("bs_mem", {48'b0, mem[8], mem[9]}, 64'hA519);
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b0, 32'd8, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    chk("bl_lat", 64'(rc), 64'd3);
    chk("bl_data", {32'b0, rd}, 64'h0000_00A5);
    chk("bl_nre", 64'(nre), 64'd1);

    // range boundary
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b1, 32'd20, 32'h0);
    req_valid = 1'b0;
    chk("oor_lat", 64'(rc), 64'd1);
    chk("oor_resp", {31'b0, er, rd}, {32'd1, 32'd0});
    chk("oor_strb", {32'(nre), 32'(nwe)}, 64'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b0, 32'd21, 32'h0);
    req_valid = 1'b0;
    chk("edge_lat", 64'(rc), 64'd3);
    chk("edge_resp", {31'b0, er, rd}, {32'd0, 32'h25});

    // reset after bytes 0 and 1 of a word store are committed
    @(posedge clk);
    #1;
    p0 = pulses;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_word  = 1'b1;
    req_addr  = 32'd0;
    req_wdata = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_ctl", {59'b0, resp_valid, resp_err, mem_re, mem_we, stall}, 0);
    chk("ar_out", {mem_addr, resp_rdata}, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("ar_mem", {32'b0, mem[3], mem[2], mem[1], mem[0]}, 64'h1312CCDD);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ar_nopulse", 64'(pulses - p0), 64'd0);
    do_req(1'b0, 1'b1, 32'd0, 32'h0);
    req_valid = 1'b0;
    chk("ar_load", {32'(rc), rd}, {32'd6, 32'h1312CCDD});

    // back-to-back with req_valid held high
    @(posedge clk);
    #1;
    p0 = pulses;
    do_req(1'b1, 1'b1, 32'd12, 32'h11223344);
    chk("b2b_st", {32'(rc), 31'b0, er}, {32'd5, 32'd0});
    do_req(1'b0, 1'b1, 32'd12, 32'h0);
    req_valid = 1'b0;
    chk("b2b_ld", {32'(rc), rd}, {32'd6, 32'h11223344});
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulse", 64'(pulses - p0), 64'd2);
    chk("strobe_viol", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
